pipeline_hazard_ctrl: RTL

- Hazard/control unit that generates the stage enable and flush controls consumed by the fetch, decode and execute pipeline latches.
- Detects three conditions and converts them into latch enables, latch flushes and a PC redirect:
  - load-use hazards between the decode and execute stages;
  - branch mispredicts resolved in execute;
  - multi-cycle memory waits.
- Also produces the registered 2-bit branch-predictor counter update that is written back to the predictor table.

---
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard/control unit.
// master: datapath side (drives stage info, consumes controls).
// slave : hazard unit (consumes stage info, drives controls).
// Control outputs are level signals acting on the current stg_clk edge; the
// counter update pair is a registered valid/data pulse with no back-pressure:
// counter_upd is meaningful only in a cycle where counter_upd_valid is 1.
interface pipeline_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_rd_memory;
  logic       ex_save_to_reg;
  logic       ex_is_branch;
  logic       ex_branch_prediction;
  logic       ex_branch_taken;
  logic [1:0] ex_counter;
  logic       mem_busy;
  logic       if_ena;
  logic       id_ena;
  logic       if_x;
  logic       id_x;
  logic       ex_x;
  logic       redirect;
  logic [1:0] counter_upd;
  logic       counter_upd_valid;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_valid, ex_rd, ex_rd_memory, ex_save_to_reg, ex_is_branch,
    output ex_branch_prediction, ex_branch_taken, ex_counter, mem_busy,
    input  if_ena, id_ena, if_x, id_x, ex_x, redirect,
    input  counter_upd, counter_upd_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_valid, ex_rd, ex_rd_memory, ex_save_to_reg, ex_is_branch,
    input  ex_branch_prediction, ex_branch_taken, ex_counter, mem_busy,
    output if_ena, id_ena, if_x, id_x, ex_x, redirect,
    output counter_upd, counter_upd_valid
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control unit: converts load-use, mispredict and memory-wait
// conditions into fetch/decode/execute latch enables, flushes and a PC
// redirect, and produces the saturating 2-bit predictor counter update.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush performance counters;
// without it stall_cycles and flush_events are constant 0.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic                 stg_clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [1:0]           state,
  output logic [COUNT_W-1:0]   stall_cycles,
  output logic [COUNT_W-1:0]   flush_events
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cu_q, cu_d;
  logic       cuv_q, cuv_d;

  logic if_ena_c, id_ena_c, if_x_c, id_x_c, ex_x_c, redirect_c;
  logic run_rules;
  logic mispredict, load_use;
  logic [1:0] ctr_next;

  assign mispredict = hz.ex_valid & hz.ex_is_branch &
                      (hz.ex_branch_prediction != hz.ex_branch_taken);

  assign load_use = hz.ex_valid & hz.ex_rd_memory & hz.ex_save_to_reg &
                    (hz.ex_rd != 5'd0) & hz.id_valid &
                    ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));

  // Saturating predictor counter step toward the resolved direction.
  assign ctr_next = hz.ex_branch_taken ?
                    ((hz.ex_counter == 2'd3) ? 2'd3 : hz.ex_counter + 2'd1) :
                    ((hz.ex_counter == 2'd0) ? 2'd0 : hz.ex_counter - 2'd1);

  // Next state and same-cycle latch controls; MEM_WAIT exit reuses RUN rules.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    if_ena_c   = 1'b0;
    id_ena_c   = 1'b0;
    if_x_c     = 1'b0;
    id_x_c     = 1'b0;
    ex_x_c     = 1'b0;
    redirect_c = 1'b0;
    run_rules  = 1'b0;
    case (state_q)
      ST_RUN:      run_rules = 1'b1;
      ST_MEM_WAIT: begin
        if (!hz.mem_busy) run_rules = 1'b1;
      end
      ST_FLUSH: begin
        // Decode only sees bubbles here, so load_use is not evaluated.
        if (!hz.mem_busy) begin
          if_ena_c = 1'b1;
          id_ena_c = 1'b1;
          id_x_c   = 1'b1;
          cnt_d    = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (run_rules) begin
      if (hz.mem_busy) begin
        state_d = ST_MEM_WAIT;
      end else if (mispredict) begin
        if_ena_c   = 1'b1;
        id_ena_c   = 1'b1;
        if_x_c     = 1'b1;
        id_x_c     = 1'b1;
        redirect_c = 1'b1;
        if (FLUSH_CYCLES != 0) begin
          state_d = ST_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES);
        end else begin
          state_d = ST_RUN;
        end
      end else if (load_use) begin
        ex_x_c  = 1'b1;
        state_d = ST_RUN;
      end else begin
        if_ena_c = 1'b1;
        id_ena_c = 1'b1;
        state_d  = ST_RUN;
      end
    end
    // Controls are held inactive for as long as reset is asserted.
    if (reset) begin
      if_ena_c   = 1'b0;
      id_ena_c   = 1'b0;
      if_x_c     = 1'b0;
      id_x_c     = 1'b0;
      ex_x_c     = 1'b0;
      redirect_c = 1'b0;
    end
  end

  // Counter update: one-cycle pulse per branch leaving an unfrozen execute.
  always_comb begin
    cu_d  = cu_q;
    cuv_d = 1'b0;
    if (hz.ex_valid && hz.ex_is_branch && !hz.mem_busy) begin
      cu_d  = ctr_next;
      cuv_d = 1'b1;
    end
  end

  // State, flush down-counter and counter-update registers.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      cu_q    <= 2'd0;
      cuv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cu_q    <= cu_d;
      cuv_q   <= cuv_d;
    end
  end

  assign hz.if_ena            = if_ena_c;
  assign hz.id_ena            = id_ena_c;
  assign hz.if_x              = if_x_c;
  assign hz.id_x              = id_x_c;
  assign hz.ex_x              = ex_x_c;
  assign hz.redirect          = redirect_c;
  assign hz.counter_upd       = cu_q;
  assign hz.counter_upd_valid = cuv_q;
  assign state                = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [COUNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  // Wrapping counts of decode-stall cycles and mispredicts acted on.
  always_comb begin
    stall_d = stall_q + (id_ena_c ? COUNT_W'(0) : COUNT_W'(1));
    flush_d = flush_q + (redirect_c ? COUNT_W'(1) : COUNT_W'(0));
  end

  // Performance counter registers.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule
